// File: rtl/coeff_unloader.sv
// Purpose : serialises one captured transform coefficient block onto a valid/ready word stream.
// Latency : first word is valid one cycle after the blk_valid rising edge; one word per accepted transfer.
// Backpress: dout_ready low holds dout, dout_last and the word index; blocks arriving while busy are dropped (ovf).
// Optional : define COEFF_UNLOAD_PARITY_EN to add dout_par, the even parity of dout.
module coeff_unloader #(
  parameter int DW    = 12,
  parameter int NCOEF = 8
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                blk_valid,
  input  logic [1:0]          sel,
  input  logic [NCOEF*DW-1:0] blk_data,
  output logic [DW-1:0]       dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                dout_last,
  output logic                busy,
  output logic                unload_done,
  output logic                ovf,
  output logic                sel_err
`ifdef COEFF_UNLOAD_PARITY_EN
  ,
  output logic                dout_par
`endif
);

  localparam logic [1:0] MODE_DFT = 2'b10;
  localparam logic [1:0] MODE_BAD = 2'b01;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    STREAM = 2'b01,
    DONE   = 2'b10
  } state_t;

  state_t                state, state_nxt;
  logic                  blk_valid_q;
  logic [NCOEF*DW-1:0]   hold_data;
  logic [1:0]            hold_sel;
  logic [2:0]            idx, idx_nxt, idx_inc, len_m1;
  logic [DW-1:0]         dout_nxt;
  logic                  rise, xfer, capture, sel_bad, ovf_set;

  // Edge detect against the registered copy; the copy resets low so a level
  // already high when reset releases counts as a fresh block.
  assign rise    = blk_valid & ~blk_valid_q;
  assign xfer    = dout_valid & dout_ready;
  // DFT blocks carry bins 0..4 only; the other modes use all eight words.
  assign len_m1  = (hold_sel == MODE_DFT) ? 3'd4 : 3'd7;
  assign idx_inc = idx + 3'd1;

  assign dout_valid  = (state == STREAM);
  assign dout_last   = (state == STREAM) && (idx == len_m1);
  assign busy        = (state != IDLE);
  assign unload_done = (state == DONE);

  // Next-state, capture/error decisions and the next word to present.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    sel_bad   = 1'b0;
    ovf_set   = 1'b0;
    idx_nxt   = idx;
    dout_nxt  = dout;
    case (state)
      IDLE: begin
        if (rise) begin
          if (sel == MODE_BAD) begin
            sel_bad = 1'b1;
          end else begin
            capture   = 1'b1;
            idx_nxt   = 3'd0;
            dout_nxt  = blk_data[DW-1:0];
            state_nxt = STREAM;
          end
        end
      end
      STREAM: begin
        ovf_set = rise;
        if (xfer) begin
          if (dout_last) begin
            idx_nxt   = 3'd0;
            dout_nxt  = '0;
            state_nxt = DONE;
          end else begin
            idx_nxt  = idx_inc;
            dout_nxt = hold_data[int'(idx_inc)*DW +: DW];
          end
        end
      end
      DONE: begin
        // An edge landing on the DONE cycle is too late to capture.
        ovf_set   = rise;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Holding register, word index, output word and sticky error flags.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      blk_valid_q <= 1'b0;
      hold_data   <= '0;
      hold_sel    <= 2'b00;
      idx         <= 3'd0;
      dout        <= '0;
      ovf         <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      blk_valid_q <= blk_valid;
      idx         <= idx_nxt;
      dout        <= dout_nxt;
      if (capture) begin
        hold_data <= blk_data;
        hold_sel  <= sel;
      end
      if (ovf_set) begin
        ovf <= 1'b1;
      end
      if (sel_bad) begin
        sel_err <= 1'b1;
      end
    end
  end

`ifdef COEFF_UNLOAD_PARITY_EN
  // Parity is registered from the same next word so it always matches dout.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      dout_par <= 1'b0;
    end else begin
      dout_par <= ^dout_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_coeff_unloader.sv
module tb_coeff_unloader;
  localparam int DW    = 12;
  localparam int NCOEF = 8;

  logic                clock = 1'b0;
  logic                rst;
  logic                blk_valid;
  logic [1:0]          sel;
  logic [NCOEF*DW-1:0] blk_data;
  logic [DW-1:0]       dout;
  logic                dout_valid;
  logic                dout_ready;
  logic                dout_last;
  logic                busy;
  logic                unload_done;
  logic                ovf;
  logic                sel_err;
`ifdef COEFF_UNLOAD_PARITY_EN
  logic                dout_par;
`endif

  coeff_unloader #(.DW(DW), .NCOEF(NCOEF)) dut (
    .clock       (clock),
    .rst         (rst),
    .blk_valid   (blk_valid),
    .sel         (sel),
    .blk_data    (blk_data),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_last   (dout_last),
    .busy        (busy),
    .unload_done (unload_done),
    .ovf         (ovf),
    .sel_err     (sel_err)
`ifdef COEFF_UNLOAD_PARITY_EN
    ,
    .dout_par    (dout_par)
`endif
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model: a queue of words still owed to the stream.
  int m_q[$];
  bit m_busy = 0, m_done = 0, m_prev = 0, m_ovf = 0, m_err = 0, m_rise = 0;

  int log_q[$];
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NCOEF*DW-1:0] mk_blk(input int base);
    logic [NCOEF*DW-1:0] b;
    b = '0;
    for (int i = 0; i < NCOEF; i++) b[i*DW +: DW] = DW'(base + i);
    return b;
  endfunction

  always @(posedge clock or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_busy = 0; m_done = 0; m_prev = 0; m_ovf = 0; m_err = 0;
    end else begin
      m_rise = blk_valid && !m_prev;
      m_prev = blk_valid;
      if (m_done) begin
        m_done = 0;
        m_busy = 0;
        if (m_rise) m_ovf = 1;
      end else if (m_busy) begin
        if (m_rise) m_ovf = 1;
        if (dout_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_done = 1;
        end
      end else if (m_rise) begin
        if (sel == 2'b01) begin
          m_err = 1;
        end else begin
          for (int i = 0; i < ((sel == 2'b10) ? 5 : 8); i++)
            m_q.push_back(int'(blk_data[i*DW +: DW]));
          m_busy = 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    logic [DW-1:0] w;
    chk("busy", busy, m_busy);
    chk("unload_done", unload_done, m_done);
    chk("dout_valid", dout_valid, m_busy && !m_done);
    chk("ovf", ovf, m_ovf);
    chk("sel_err", sel_err, m_err);
    if (m_busy && !m_done) begin
      w = DW'(m_q[0]);
      chk("dout", dout, w);
      chk("dout_last", dout_last, m_q.size() == 1);
`ifdef COEFF_UNLOAD_PARITY_EN
      chk("dout_par", dout_par, ^w);
      if (w == 12'h0F3) chk("par_0F3", dout_par, 0);
`endif
    end else begin
      chk("dout_last_idle", dout_last, 0);
    end
    if (!rst) begin
      chk("dout_rst", dout, 0);
`ifdef COEFF_UNLOAD_PARITY_EN
      chk("dout_par_rst", dout_par, 0);
`endif
    end
    if (dout_valid && dout_ready) log_q.push_back(int'(dout));
    if (unload_done) done_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse(input logic [1:0] s, input int base);
    sel = s;
    blk_data = mk_blk(base);
    blk_valid = 1'b1;
    tick(1);
    blk_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 100; k++) begin
      if (!busy) break;
      tick(1);
    end
    if (k == 100) begin
      n_vec++; n_bad++;
      $display("FAIL %s_timeout: busy still 1 expected 0", name);
    end
  endtask

  task automatic wait_word(input string name, input int val);
    int k;
    for (k = 0; k < 50; k++) begin
      if (dout_valid && dout == DW'(val)) break;
      tick(1);
    end
    if (k == 50) begin
      n_vec++; n_bad++;
      $display("FAIL %s_timeout: word %0h never shown", name, val);
    end
  endtask

  task automatic check_log(input string name, input int base, input int n, input int ndone);
    chk({name, "_count"}, log_q.size(), n);
    for (int i = 0; i < log_q.size() && i < n; i++)
      chk({name, "_word"}, log_q[i], (base + i) & 'hFFF);
    chk({name, "_done"}, done_cnt, ndone);
    log_q.delete();
    done_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(2);
    log_q.delete();
    done_cnt = 0;
    rst = 1'b1;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b0; blk_valid = 1'b0; sel = 2'b00; blk_data = '0; dout_ready = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(2);

    // DCT drain, inputs scrambled after capture
    pulse(2'b00, 1);
    chk("dct_lat", dout_valid, 1);
    chk("dct_first", dout, 12'h001);
    sel = 2'b10; blk_data = '1;
    wait_idle("dct");
    check_log("dct", 1, 8, 1);
    chk("dct_busy_after", busy, 0);

    // DFT length; new edge lands on the DONE cycle
    pulse(2'b10, 10);
    for (k = 0; k < 50; k++) begin
      @(negedge clock);
      if (dout_last === 1'b1) break;
    end
    if (k == 50) begin n_vec++; n_bad++; $display("FAIL dft_last_timeout: no dout_last"); end
    chk("dft_last_word", dout, 12'd14);
    @(posedge clock); #1;
    blk_valid = 1'b1; sel = 2'b00; blk_data = mk_blk('h60);
    tick(3);
    blk_valid = 1'b0;
    tick(2);
    check_log("dft", 10, 5, 1);
    chk("done_edge_ovf", ovf, 1);

    // Backpressure on HWT word 3
    do_reset();
    chk("rst_ovf_clear", ovf, 0);
    pulse(2'b11, 'h20);
    wait_word("bp", 'h22);
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("bp_hold", dout, 12'h022);
    end
    dout_ready = 1'b1;
    wait_idle("bp");
    check_log("hwt", 'h20, 8, 1);
    chk("bp_no_ovf", ovf, 0);

    // Overflow during STREAM
    pulse(2'b00, 'h30);
    tick(2);
    pulse(2'b11, 'h40);
    wait_idle("ovf");
    tick(2);
    check_log("ovf", 'h30, 8, 1);
    chk("ovf_set", ovf, 1);

    // Illegal mode, then a held-high blk_valid
    do_reset();
    pulse(2'b01, 'h70);
    tick(3);
    chk("bad_sel_err", sel_err, 1);
    chk("bad_no_valid", dout_valid, 0);
    check_log("bad", 0, 0, 0);
    sel = 2'b00; blk_data = mk_blk('h50); blk_valid = 1'b1;
    tick(1);
    wait_idle("hold");
    tick(5);
    blk_valid = 1'b0;
    tick(2);
    check_log("hold", 'h50, 8, 1);

    // Mid-stream reset, then a level already high at release
    pulse(2'b00, 'h80);
    wait_word("mrst", 'h83);
    rst = 1'b0;
    #1;
    chk("mrst_valid", dout_valid, 0);
    chk("mrst_dout", dout, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_last", dout_last, 0);
    chk("mrst_sel_err", sel_err, 0);
    tick(1);
    chk("mrst_no_done", done_cnt, 0);
    log_q.delete();
    done_cnt = 0;
    sel = 2'b00; blk_data = mk_blk('hF0); blk_valid = 1'b1;
    rst = 1'b1;
    tick(1);
    blk_valid = 1'b0;
    chk("fresh_first", dout, 12'h0F0);
    wait_idle("fresh");
    tick(2);
    check_log("fresh", 'hF0, 8, 1);

    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/coeff_unloader.md
COEFF_UNLOADER -- requirements
Module: coeff_unloader

Interface
REQ-001 SHALL have parameter DW, default 12, width of one transform coefficient word.
REQ-002 SHALL have parameter NCOEF, default 8, words per transform block; fixed at 8 for this core.
REQ-003 Ports (name direction width meaning):
- clock  input  1  single clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset
- blk_valid  input  1  level from the transform controller: result block present
- sel  input  2  transform mode: 11 HWT, 00 DCT, 10 DFT, 01 illegal
- blk_data  input  NCOEF*DW  coefficient block; word i at bits [i*DW+DW-1 : i*DW]
- dout  output  DW  streamed coefficient
- dout_valid  output  1  dout holds a word
- dout_ready  input  1  downstream accepts the word
- dout_last  output  1  current word is the final word of the block
- busy  output  1  block captured and not yet fully drained
- unload_done  output  1  one-cycle pulse after the final transfer
- ovf  output  1  sticky: block dropped while busy
- sel_err  output  1  sticky: illegal sel at capture

Function
REQ-004 SHALL use states IDLE, STREAM and DONE.
REQ-005 SHALL detect the rising edge of blk_valid: registered copy low, current value high.
REQ-006 IDLE with rising edge and legal sel: SHALL capture blk_data and sel into a holding register, clear the index to 0, and go to STREAM. dout_valid SHALL rise on the next edge, giving 1-cycle latency.
REQ-007 IDLE with rising edge and sel==01: SHALL set sel_err, capture nothing, and stay in IDLE.
REQ-008 Block length SHALL come from the captured sel: 5 words for DFT (bins 0..4), 8 words for HWT and DCT.
REQ-009 In STREAM, dout SHALL equal word[index] of the held block, and dout_valid SHALL be 1.
REQ-010 A transfer SHALL occur on an edge where dout_valid && dout_ready. The index SHALL advance by 1 only on a transfer.
REQ-011 While dout_valid && !dout_ready, dout, dout_last and the index SHALL hold stable.
REQ-012 dout_last SHALL be 1 exactly when index == length-1 in STREAM.
REQ-013 A transfer with dout_last SHALL move to DONE. DONE SHALL assert unload_done for exactly one cycle, then move to IDLE.
REQ-014 busy SHALL be 1 in STREAM and DONE, and 0 in IDLE.
REQ-015 A blk_valid rising edge in STREAM or DONE SHALL set ovf and drop that block; the held block SHALL continue unchanged.
REQ-016 A rising edge arriving in the same cycle DONE returns to IDLE SHALL count as an overflow and SHALL NOT be captured.
REQ-017 blk_valid held high SHALL cause no second capture. A new capture needs blk_valid to go low, then high again.
REQ-018 A change to the sel or blk_data inputs after capture SHALL NOT affect the block being streamed.
REQ-019 The index SHALL be 3 bits. It SHALL never exceed length-1 and SHALL reset to 0 on entry to STREAM.

Reset
REQ-020 rst low SHALL immediately (asynchronously) force: state IDLE, index 0, dout 0, dout_valid 0, dout_last 0, busy 0, unload_done 0, ovf 0, sel_err 0, blk_valid edge register 0.
REQ-021 Reset during STREAM SHALL abandon the block and emit no unload_done.
REQ-022 After reset release, a blk_valid already high SHALL be treated as a rising edge.
REQ-023 ovf and sel_err SHALL clear only on reset.

Configuration
REQ-024 With macro COEFF_UNLOAD_PARITY_EN defined, the module SHALL add output dout_par (1 bit):
- even parity (XOR) of dout
- registered together with dout, valid whenever dout_valid is 1
- 0 in reset
REQ-025 Without COEFF_UNLOAD_PARITY_EN, dout_par SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-026 Bench SHALL cover these scenarios:
- DCT drain: sel=00, words 1..8, dout_ready=1 -> dout 1,2,...,8 on 8 consecutive cycles; dout_last on word 8; unload_done pulse the next cycle; busy low after.
- DFT length: sel=10, words 10..17 -> only 10..14 emitted; dout_last on 14; busy 4 cycles after first word... exactly 5 transfers, then unload_done.
- Backpressure: HWT block, dout_ready low for 3 cycles at word 3 -> dout holds word 3 stable; no skip or duplicate; 8 transfers total.
- Overflow: second blk_valid rising edge during STREAM -> ovf=1; original block completes intact; second block never emitted.
- Illegal mode and hold: sel=01 edge -> sel_err=1, dout_valid stays 0. Then blk_valid held high across the end of a drain -> no recapture.
- Mid-stream reset: rst low at word 4 -> all outputs 0 at once, no unload_done; after release, a fresh block drains from word 0. Run with and without COEFF_UNLOAD_PARITY_EN; with it, check dout_par on dout=0x0F3 is 0.
